// File: rtl/mult_const_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_const_pkg
//  Description : Shared types and helpers for the sequential constant
//                multiplier (FSM states, digit count, per-digit product).
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_const_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_digits(input int coef_width, input int bits_per_cycle);
        return coef_width / bits_per_cycle;
    endfunction

    // Product of the operand with one coefficient digit group. The group that
    // holds the coefficient MSB carries negative weight on its top bit.
    function automatic logic signed [63:0] partial_product(
        input logic signed [63:0] operand,
        input logic [3:0]         digit,
        input int                 bits,
        input logic               is_last
    );
        logic signed [63:0] weight;
        weight = $signed({60'd0, digit});
        if (is_last && digit[2'(bits - 1)]) begin
            weight = weight - (64'sd1 <<< bits);
        end
        return operand * weight;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mult_coef_bank
//  Description : NUM_COEFS x COEF_WIDTH coefficient register file with one
//                synchronous write port and one combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_coef_bank #(
    parameter int COEF_WIDTH = 8,
    parameter int NUM_COEFS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic [$clog2(NUM_COEFS)-1:0] i_waddr,
    input  logic [COEF_WIDTH-1:0]        i_wdata,
    input  logic [$clog2(NUM_COEFS)-1:0] i_raddr,
    output logic [COEF_WIDTH-1:0]        o_rdata
);

    localparam int c_ADDR_W = $clog2(NUM_COEFS);

    logic [COEF_WIDTH-1:0] r_mem [NUM_COEFS];
    logic                  w_wr_hit;
    logic                  w_rd_hit;

    // Only a non-power-of-two depth has unmapped addresses to guard against.
    generate
        if (NUM_COEFS == (2 ** c_ADDR_W)) begin : g_full_map
            assign w_wr_hit = i_we;
            assign w_rd_hit = 1'b1;
        end else begin : g_partial_map
            assign w_wr_hit = i_we && (int'(i_waddr) < NUM_COEFS);
            assign w_rd_hit = (int'(i_raddr) < NUM_COEFS);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_hit ? r_mem[i_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/mult_const_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_const_seq
//  Description : Iterative shift-add signed multiplier, BITS_PER_CYCLE
//                coefficient bits per cycle, coefficient from a runtime bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_const_seq
    import mult_const_pkg::*;
#(
    parameter int IN_WIDTH       = 7,
    parameter int COEF_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 2,
    parameter int NUM_COEFS      = 4,
    parameter int OUT_WIDTH      = IN_WIDTH + COEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          inp,
    input  logic [$clog2(NUM_COEFS)-1:0] sel,
    input  logic                         coef_we,
    input  logic [$clog2(NUM_COEFS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]        coef_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out
);

    localparam int                c_N     = num_digits(COEF_WIDTH, BITS_PER_CYCLE);
    localparam int                c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    state_t                       r_state;
    logic signed [IN_WIDTH-1:0]   r_inp;
    logic [COEF_WIDTH-1:0]        r_coef;
    logic signed [OUT_WIDTH-1:0]  r_acc;
    logic [c_CNT_W-1:0]           r_count;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic signed [OUT_WIDTH-1:0]  r_out;

    logic [COEF_WIDTH-1:0]        w_rd_coef;
    logic                         w_last;
    logic [3:0]                   w_digit;
    logic signed [63:0]           w_pp;
    logic signed [OUT_WIDTH-1:0]  w_acc_next;

    mult_coef_bank #(
        .COEF_WIDTH (COEF_WIDTH),
        .NUM_COEFS  (NUM_COEFS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .i_we    (coef_we),
        .i_waddr (coef_addr),
        .i_wdata (coef_wdata),
        .i_raddr (sel),
        .o_rdata (w_rd_coef)
    );

    // r_coef shifts right each iteration, so the current digit is always at the bottom.
    // Accumulation wraps at OUT_WIDTH; the final sum always fits, so it is exact.
    always_comb begin
        w_last     = (r_count == c_LAST);
        w_digit    = 4'(r_coef[BITS_PER_CYCLE-1:0]);
        w_pp       = partial_product(64'(r_inp), w_digit, BITS_PER_CYCLE, w_last);
        w_acc_next = r_acc + OUT_WIDTH'(w_pp <<< (int'(r_count) * BITS_PER_CYCLE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_inp       <= '0;
            r_coef      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_inp      <= inp;
                        r_coef     <= w_rd_coef;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc   <= w_acc_next;
                    r_coef  <= r_coef >> BITS_PER_CYCLE;
                    r_count <= r_count + c_CNT_W'(1);
                    if (w_last) begin
                        r_out       <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mult_const_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_const_seq
//  Description : Self-checking bench for mult_const_seq at BITS_PER_CYCLE 2,
//                1 and 4 sharing one stimulus stream and one coefficient model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_const_seq;

    localparam int c_IN_W   = 7;
    localparam int c_COEF_W = 8;
    localparam int c_NUM    = 4;
    localparam int c_OUT_W  = c_IN_W + c_COEF_W;
    localparam int c_INST   = 3;

    logic                        clk;
    logic                        rst;
    logic                        in_valid;
    logic signed [c_IN_W-1:0]    inp;
    logic [1:0]                  sel;
    logic                        coef_we;
    logic [1:0]                  coef_addr;
    logic signed [c_COEF_W-1:0]  coef_wdata;
    logic                        out_ready;

    logic                        in_ready_v  [c_INST];
    logic                        out_valid_v [c_INST];
    logic signed [c_OUT_W-1:0]   out_v       [c_INST];

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: coefficient bank and one outstanding product per instance.
    longint bank_m   [c_NUM];
    bit     pending  [c_INST];
    longint exp_prod [c_INST];

    genvar k;
    generate
        for (k = 0; k < c_INST; k++) begin : g_dut
            localparam int c_BPC = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
            mult_const_seq #(
                .IN_WIDTH       (c_IN_W),
                .COEF_WIDTH     (c_COEF_W),
                .BITS_PER_CYCLE (c_BPC),
                .NUM_COEFS      (c_NUM)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid),
                .in_ready   (in_ready_v[k]),
                .inp        (inp),
                .sel        (sel),
                .coef_we    (coef_we),
                .coef_addr  (coef_addr),
                .coef_wdata (coef_wdata),
                .out_valid  (out_valid_v[k]),
                .out_ready  (out_ready),
                .out        (out_v[k])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        n_total++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Inputs change at posedge+1, so at negedge they show what the next edge samples.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_INST; i++) pending[i] = 1'b0;
            for (int i = 0; i < c_NUM; i++) bank_m[i] = 0;
        end else begin
            for (int i = 0; i < c_INST; i++) begin
                if (out_valid_v[i] && out_ready) begin
                    check($sformatf("sb_expected_inst%0d", i), longint'(pending[i]), 1);
                    check($sformatf("sb_product_inst%0d", i), longint'(out_v[i]), exp_prod[i]);
                    pending[i] = 1'b0;
                end
                if (in_valid && in_ready_v[i]) begin
                    pending[i]  = 1'b1;
                    exp_prod[i] = longint'(inp) * bank_m[sel];
                end
            end
            if (coef_we) bank_m[coef_addr] = longint'(coef_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int g = 0; g < 100 && !in_ready_v[0]; g++) step();
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_we    = 1'b1;
        coef_addr  = 2'(addr);
        coef_wdata = 8'(data);
        step();
        coef_we    = 1'b0;
    endtask

    // One operation on the BITS_PER_CYCLE=2 instance, optionally with a
    // coefficient write in the accepting cycle; returns product and latency.
    task automatic run_op(input int a, input int s, input int we, input int waddr,
                          input int wdata, output longint prod, output int lat);
        wait_ready();
        in_valid   = 1'b1;
        inp        = 7'(a);
        sel        = 2'(s);
        coef_we    = (we != 0);
        coef_addr  = 2'(waddr);
        coef_wdata = 8'(wdata);
        step();
        in_valid   = 1'b0;
        coef_we    = 1'b0;
        lat  = 0;
        prod = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (out_valid_v[0]) begin
                lat  = c;
                prod = longint'(out_v[0]);
                break;
            end
        end
        step();
    endtask

    typedef struct {
        int     a;
        int     s;
        int     we;
        int     waddr;
        int     wdata;
        longint expv;
    } vec_t;

    vec_t   vecs [9];
    longint prod;
    int     lat;

    initial begin
        vecs[0] = '{-64, 0, 0, 0, 0,   -3648};
        vecs[1] = '{-64, 1, 0, 0, 0,    8192};
        vecs[2] = '{ 63, 2, 0, 0, 0,    8001};
        vecs[3] = '{ 63, 3, 0, 0, 0,   -8064};
        vecs[4] = '{ -3, 1, 1, 1, 5,     384};
        vecs[5] = '{ -3, 1, 0, 0, 0,     -15};
        vecs[6] = '{  0, 0, 0, 0, 0,       0};
        vecs[7] = '{ -1, 2, 0, 0, 0,    -127};
        vecs[8] = '{  1, 3, 0, 0, 0,    -128};

        rst = 1'b1; in_valid = 1'b0; inp = '0; sel = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
        repeat (2) step();
        check("reset_in_ready",  longint'(in_ready_v[0]),  1);
        check("reset_out_valid", longint'(out_valid_v[0]), 0);
        check("reset_out",       longint'(out_v[0]),       0);
        rst = 1'b0;

        write_coef(0, 57);
        write_coef(1, -128);
        write_coef(2, 127);
        write_coef(3, -128);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].s, vecs[i].we, vecs[i].waddr, vecs[i].wdata, prod, lat);
            check($sformatf("vec%0d_product", i), prod, vecs[i].expv);
            check($sformatf("vec%0d_latency", i), longint'(lat), 4);
        end

        // Backpressure: product held for 3 cycles while another operand is offered.
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1; inp = 7'(5); sel = 2'd2;
        step();
        inp = 7'(7); sel = 2'd0;
        for (int g = 0; g < 20 && !out_valid_v[0]; g++) step();
        for (int c = 0; c < 3; c++) begin
            check("stall_out_valid", longint'(out_valid_v[0]), 1);
            check("stall_out",       longint'(out_v[0]),       635);
            check("stall_in_ready",  longint'(in_ready_v[0]),  0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("release_out_valid", longint'(out_valid_v[0]), 0);
        check("release_in_ready",  longint'(in_ready_v[0]),  1);
        run_op(7, 0, 0, 0, 0, prod, lat);
        check("after_stall_product", prod, 399);

        // Reset two iterations into an operation.
        wait_ready();
        in_valid = 1'b1; inp = 7'(9); sel = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", longint'(out_valid_v[0]), 0);
        check("midrst_in_ready",  longint'(in_ready_v[0]),  1);
        run_op(10, 0, 0, 0, 0, prod, lat);
        check("midrst_bank0_cleared", prod, 0);
        run_op(-64, 3, 0, 0, 0, prod, lat);
        check("midrst_bank3_cleared", prod, 0);

        // Random traffic, coefficient writes and stalls, checked by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            inp        = 7'($urandom);
            if ($urandom_range(0, 7) == 0) inp = 7'h40;
            sel        = 2'($urandom);
            coef_we    = ($urandom_range(0, 9) < 2);
            coef_addr  = 2'($urandom);
            coef_wdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) coef_wdata = 8'h80;
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();
        for (int i = 0; i < c_INST; i++) begin
            check($sformatf("drained_inst%0d", i), longint'(pending[i]), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
